// File: rtl/hazard_ctl_pkg.sv
// Shared constants for the pipeline hazard controller: register "none" code,
// md timer state encoding and default mult/div latency.
package hazard_ctl_pkg;
  // $zero is never a real dependency, so it doubles as the "no register" code.
  localparam logic [4:0] RNONE  = 5'd0;
  localparam int         MD_LAT = 4;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_MDWAIT = 1'b1
  } hzState_t;
endpackage

// File: rtl/hazard_ctl_md_timer.sv
// Mult/div busy timer: RUN/MDWAIT FSM with a countdown that holds while the
// pipeline is frozen.
module md_timer
  import hazard_ctl_pkg::*;
#(
  parameter int MD_LAT = hazard_ctl_pkg::MD_LAT,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  output logic busy
);
  hzState_t           state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      HZ_RUN: begin
        if (start && !hold) begin
          stateNext = HZ_MDWAIT;
          cntNext   = CNT_W'(MD_LAT - 1);
        end
      end
      HZ_MDWAIT: begin
        // A start seen here is impossible with D stalled; it is simply dropped.
        if (!hold) begin
          if (cnt == CNT_W'(1)) begin
            stateNext = HZ_RUN;
            cntNext   = '0;
          end else begin
            cntNext = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        stateNext = HZ_RUN;
        cntNext   = '0;
      end
    endcase
  end

  assign busy = (state == HZ_MDWAIT);
endmodule

// File: rtl/hazard_ctl.sv
// Stall/bubble control for the 5-stage pipeline: load-use, HI/LO busy,
// branch mispredict and halt, resolved in fixed priority.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int MD_LAT = hazard_ctl_pkg::MD_LAT,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] d_srcA,
  input  logic [4:0] d_srcB,
  input  logic [4:0] E_dstM,
  input  logic       d_use_hilo,
  input  logic       d_md_op,
  input  logic       E_md_op,
  input  logic       e_mispred,
  input  logic       W_halt,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       md_busy,
  output logic       halted
);
  logic haltedQ;
  logic freeze;
  logic loadUse;
  logic mdHazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      haltedQ <= 1'b0;
    else if (W_halt) haltedQ <= 1'b1;
  end

  assign freeze = W_halt || haltedQ;
  assign halted = haltedQ;

  md_timer #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) uTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (E_md_op),
    .hold  (freeze),
    .busy  (md_busy)
  );

  assign loadUse  = (E_dstM != RNONE) && (E_dstM == d_srcA || E_dstM == d_srcB);
  // The op sitting in E is about to occupy HI/LO, so it already blocks readers.
  assign mdHazard = (md_busy || E_md_op) && (d_use_hilo || d_md_op);

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    if (freeze) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
    end else if (e_mispred) begin
      // D holds a wrong-path instruction, so its hazards are irrelevant.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
    end else if (loadUse || mdHazard) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_hazard_ctl;
  localparam int         LAT   = 4;
  localparam logic [4:0] RNONE = 5'd0;

  logic       clk, rst_n;
  logic [4:0] d_srcA, d_srcB, E_dstM;
  logic       d_use_hilo, d_md_op, E_md_op, e_mispred, W_halt;
  logic       F_stall, D_stall, D_bubble, E_bubble, md_busy, halted;

  int checks = 0;
  int errors = 0;

  // model state: remaining busy cycles and halt latch
  int mBusyLeft = 0;
  bit mHalted   = 0;

  hazard_ctl #(.MD_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
    .d_use_hilo(d_use_hilo), .d_md_op(d_md_op), .E_md_op(E_md_op),
    .e_mispred(e_mispred), .W_halt(W_halt), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .md_busy(md_busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] expOut();
    bit frz, lu, mdh;
    frz = W_halt || mHalted;
    lu  = (E_dstM != RNONE) && (E_dstM == d_srcA || E_dstM == d_srcB);
    mdh = ((mBusyLeft > 0) || E_md_op) && (d_use_hilo || d_md_op);
    if (frz)            return 4'b1100;   // {F_stall, D_stall, D_bubble, E_bubble}
    else if (e_mispred) return 4'b0011;
    else if (lu || mdh) return 4'b1101;
    else                return 4'b0000;
  endfunction

  task automatic modelEdge();
    if (!(W_halt || mHalted)) begin
      if (mBusyLeft > 0)  mBusyLeft--;
      else if (E_md_op)   mBusyLeft = LAT - 1;
    end
    if (W_halt) mHalted = 1;
  endtask

  // advance one clock, updating the model with the pre-edge inputs
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleInputs();
    d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE;
    d_use_hilo = 0; d_md_op = 0; E_md_op = 0; e_mispred = 0; W_halt = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 0;
    E_md_op = 1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble, md_busy, halted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {F_stall, D_stall, D_bubble, E_bubble, md_busy, halted});
    end
    E_md_op = 0;
    mBusyLeft = 0; mHalted = 0;
    rst_n = 1;
  endtask

  task automatic test_load_use();
    tick();
    idleInputs();
    E_dstM = 5'd8; d_srcA = 5'd8;
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin
      errors++;
      $display("FAIL load_use: got %b want 1101", {F_stall, D_stall, D_bubble, E_bubble});
    end
    tick();
    E_dstM = RNONE;
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000) begin
      errors++;
      $display("FAIL load_use_clear: got %b want 0000", {F_stall, D_stall, D_bubble, E_bubble});
    end
    // match on srcB only
    tick();
    E_dstM = 5'd17; d_srcA = 5'd3; d_srcB = 5'd17;
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin
      errors++;
      $display("FAIL load_use_srcB: got %b want 1101", {F_stall, D_stall, D_bubble, E_bubble});
    end
  endtask

  task automatic test_no_false_hazard();
    tick();
    idleInputs();
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000) begin
      errors++;
      $display("FAIL none_rnone: got %b want 0000", {F_stall, D_stall, D_bubble, E_bubble});
    end
    tick();
    E_dstM = 5'd9; d_srcB = 5'd10;
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000) begin
      errors++;
      $display("FAIL none_diff_reg: got %b want 0000", {F_stall, D_stall, D_bubble, E_bubble});
    end
  endtask

  task automatic test_md_hilo();
    tick();
    idleInputs();
    E_md_op = 1; d_use_hilo = 1;
    #2;
    checks++;
    if ({F_stall, D_stall, E_bubble, md_busy} !== 4'b1110) begin
      errors++;
      $display("FAIL md_cycle0: got %b want 1110", {F_stall, D_stall, E_bubble, md_busy});
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      E_md_op = 0;
      #2;
      checks++;
      if (md_busy !== (c <= LAT - 1) || F_stall !== (c <= LAT - 1)) begin
        errors++;
        $display("FAIL md_cycle%0d: busy=%b stall=%b want %b", c, md_busy, F_stall, c <= LAT - 1);
      end
    end
    d_use_hilo = 0;
  endtask

  task automatic test_mispred();
    tick();
    idleInputs();
    e_mispred = 1; E_dstM = 5'd5; d_srcA = 5'd5;
    #2;
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0011) begin
      errors++;
      $display("FAIL mispred_over_lu: got %b want 0011", {F_stall, D_stall, D_bubble, E_bubble});
    end
    e_mispred = 0;
  endtask

  task automatic test_random();
    logic [4:0] regs [4] = '{5'd0, 5'd5, 5'd8, 5'd9};
    for (int i = 0; i < 600; i++) begin
      tick();
      if (mHalted && $urandom_range(0, 15) == 0) begin
        rst_n = 0; #1 rst_n = 1;
        mBusyLeft = 0; mHalted = 0;
      end
      d_srcA     = regs[$urandom_range(0, 3)];
      d_srcB     = regs[$urandom_range(0, 3)];
      E_dstM     = regs[$urandom_range(0, 3)];
      d_use_hilo = ($urandom_range(0, 3) == 0);
      d_md_op    = ($urandom_range(0, 5) == 0);
      E_md_op    = ($urandom_range(0, 4) == 0);
      e_mispred  = ($urandom_range(0, 5) == 0);
      W_halt     = ($urandom_range(0, 80) == 0);
      #1;
      checks++;
      if ({F_stall, D_stall, D_bubble, E_bubble} !== expOut() ||
          md_busy !== (mBusyLeft > 0) || halted !== mHalted) begin
        errors++;
        $display("FAIL rand[%0d]: out=%b busy=%b halted=%b want out=%b busy=%b halted=%b",
                 i, {F_stall, D_stall, D_bubble, E_bubble}, md_busy, halted,
                 expOut(), mBusyLeft > 0, mHalted);
      end
    end
    rst_n = 0; #1 rst_n = 1;
    mBusyLeft = 0; mHalted = 0;
    idleInputs();
  endtask

  task automatic test_halt();
    for (int c = 0; c <= 8; c++) begin
      tick();
      idleInputs();
      W_halt    = (c == 5);
      e_mispred = (c >= 6);
      #2;
      if (c >= 5) begin
        checks++;
        if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1100 || halted !== (c >= 6)) begin
          errors++;
          $display("FAIL halt_cycle%0d: out=%b halted=%b want out=1100 halted=%b",
                   c, {F_stall, D_stall, D_bubble, E_bubble}, halted, c >= 6);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int busyCnt;
    // currently halted: reset must clear it without waiting for an edge
    tick();
    idleInputs();
    #1 rst_n = 0;
    #1;
    checks++;
    if ({halted, md_busy, F_stall, D_stall} !== 4'b0) begin
      errors++;
      $display("FAIL reset_halted: got %b want 0000", {halted, md_busy, F_stall, D_stall});
    end
    rst_n = 1;
    mBusyLeft = 0; mHalted = 0;
    // start mult, reach cnt=2, then reset mid-cycle
    tick();
    E_md_op = 1;
    tick();
    E_md_op = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({md_busy, halted} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mdwait: got %b want 00", {md_busy, halted});
    end
    rst_n = 1;
    mBusyLeft = 0;
    tick();
    E_md_op = 1;
    tick();
    E_md_op = 0;
    busyCnt = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (md_busy === 1'b1) busyCnt++;
      tick();
    end
    checks++;
    if (busyCnt != LAT - 1) begin
      errors++;
      $display("FAIL restart_window: busy cycles %0d want %0d", busyCnt, LAT - 1);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_md_hilo();
    test_mispred();
    test_random();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
